// File: rtl/tb_uart_if.sv
// tb_uart_if: serial pins plus the parallel TX/RX side of tb_uart.
// master is the user/driver side, slave is the UART itself.
interface tb_uart_if;
    logic       ser_rx;
    logic       ser_tx;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    modport master (
        output ser_rx, tx_start, tx_data,
        input  ser_tx, tx_busy, tx_clear_req,
        input  rx_data, rx_valid, rx_error
    );

    modport slave (
        input  ser_rx, tx_start, tx_data,
        output ser_tx, tx_busy, tx_clear_req,
        output rx_data, rx_valid, rx_error
    );
endinterface

// File: rtl/tb_uart.sv
// tb_uart: 8N1 UART with independent TX and RX state machines.
// Define TB_UART_PRINT_EN to echo received lines to the simulation log.
module tb_uart #(
    parameter int CLKS_PER_BIT = 347
) (
    input logic      clock,
    input logic      resetb,
    tb_uart_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_tx_st;
    logic [CW-1:0]   r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_sh;
    logic            r_tx_q;
    logic            r_ser_tx;
    logic            r_tx_busy;
    logic            r_tx_clr;
    logic            w_tx_rise;

    // edge register tracks tx_start even while busy, so edges then are lost
    assign w_tx_rise = bus.tx_start & ~r_tx_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_tx_st   <= S_IDLE;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_sh   <= '0;
            r_tx_q    <= 1'b0;
            r_ser_tx  <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_clr  <= 1'b0;
        end else begin
            r_tx_q   <= bus.tx_start;
            r_tx_clr <= 1'b0;
            unique case (r_tx_st)
                S_IDLE: begin
                    if (w_tx_rise) begin
                        r_tx_st   <= S_START;
                        r_tx_sh   <= bus.tx_data;
                        r_tx_cnt  <= '0;
                        r_ser_tx  <= 1'b0;
                        r_tx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_st  <= S_DATA;
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_ser_tx <= r_tx_sh[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_st  <= S_STOP;
                            r_ser_tx <= 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_ser_tx <= r_tx_sh[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tx_cnt == LAST) begin
                        r_tx_st   <= S_IDLE;
                        r_tx_cnt  <= '0;
                        r_tx_busy <= 1'b0;
                        r_tx_clr  <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_st <= S_IDLE;
            endcase
        end
    end

    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_s3;
    state_t          r_rx_st;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_sh;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_rx_err;
    logic            w_rx_fall;

    // s1/s2 synchronize; s3 only holds the previous value for edge detect
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_st    <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_s1    <= bus.ser_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            unique case (r_rx_st)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_st  <= S_START;
                        r_rx_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_st <= S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_rx_cnt == LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= S_IDLE;
                        if (r_rx_s2) begin
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end

    assign bus.ser_tx       = r_ser_tx;
    assign bus.tx_busy      = r_tx_busy;
    assign bus.tx_clear_req = r_tx_clr;
    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.rx_error     = r_rx_err;

`ifdef TB_UART_PRINT_EN
    string r_line;

    // line feed or a full 128-character buffer flushes the line
    always @(posedge clock) begin
        if (r_rx_valid) begin
            if (r_rx_data == 8'h0A) begin
                $display("tbuart: %s", r_line);
                r_line <= "";
            end else if (r_line.len() >= 127) begin
                $display("tbuart: %s%c", r_line, r_rx_data);
                r_line <= "";
            end else begin
                r_line <= $sformatf("%s%c", r_line, r_rx_data);
            end
        end
        if (r_rx_err) begin
            $display("tbuart: framing error");
        end
    end
`endif
endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: randomized checks of tb_uart TX/RX against a frame-level model.
// Serial frames are modelled as {stop, data, start} bit lists of CPB cycles each.
module tb_tb_uart;
    localparam int CPB = 347;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests;
    int   n_fail;

    tb_uart_if u_if ();

    tb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clock  (clk),
        .resetb (rstn),
        .bus    (u_if)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_got[$];
    int         rx_err_n;
    logic [7:0] last_good;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (u_if.rx_valid === 1'b1) rx_got.push_back(u_if.rx_data);
            if (u_if.rx_error === 1'b1) rx_err_n++;
        end
    end

    logic cap_wave[$];
    int   cap_lat;
    int   cap_busy;
    int   cap_clr;
    logic cap_clr_end;
    logic cap_idle;

    function automatic logic tx_bit(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic int wave_err(input logic [7:0] d);
        int e;
        e = 0;
        foreach (cap_wave[k]) begin
            if (cap_wave[k] !== tx_bit(d, k)) e++;
        end
        if (cap_wave.size() != 10 * CPB) e += 1000000;
        return e;
    endfunction

    // Records one transmit frame; called on the negedge where tx_start rises.
    task automatic capture_tx(input bit drop_on_clr);
        int guard;
        cap_wave.delete();
        cap_busy = 0;
        cap_clr  = 0;
        @(negedge clk);
        cap_lat = 1;
        guard = 0;
        while (u_if.tx_busy !== 1'b1 && guard < 8) begin
            @(negedge clk);
            cap_lat++;
            guard++;
        end
        guard = 0;
        while (u_if.tx_busy === 1'b1 && guard < 12 * CPB) begin
            cap_wave.push_back(u_if.ser_tx);
            cap_busy++;
            if (u_if.tx_clear_req === 1'b1) cap_clr++;
            @(negedge clk);
            guard++;
        end
        cap_clr_end = u_if.tx_clear_req;
        cap_idle    = u_if.ser_tx;
        if (u_if.tx_clear_req === 1'b1) cap_clr++;
        if (drop_on_clr && u_if.tx_clear_req === 1'b1) u_if.tx_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (u_if.tx_clear_req === 1'b1) cap_clr++;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stopb);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.ser_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.ser_rx = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({u_if.ser_tx, u_if.tx_busy, u_if.tx_clear_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_tx: got %b want 100",
                     {u_if.ser_tx, u_if.tx_busy, u_if.tx_clear_req});
        end
        n_tests++;
        if ({u_if.rx_data, u_if.rx_valid, u_if.rx_error} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_rx: got %h want 000",
                     {u_if.rx_data, u_if.rx_valid, u_if.rx_error});
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({u_if.ser_tx, u_if.tx_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 10",
                     {u_if.ser_tx, u_if.tx_busy});
        end
    endtask

    task automatic test_tx_frame();
        int e;
        u_if.tx_data  = 8'h3D;
        u_if.tx_start = 1'b1;
        capture_tx(1'b1);
        n_tests++;
        if (cap_lat !== 1) begin
            n_fail++;
            $display("FAIL tx_latency: got %0d want 1", cap_lat);
        end
        e = wave_err(8'h3D);
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL tx_wave_3d: got %0d bad cycles want 0", e);
        end
        n_tests++;
        if (cap_busy !== 10 * CPB) begin
            n_fail++;
            $display("FAIL tx_busy_len: got %0d want %0d", cap_busy, 10 * CPB);
        end
        n_tests++;
        if (cap_clr !== 1 || cap_clr_end !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_clear_req: got %0d pulses end=%b want 1 end=1",
                     cap_clr, cap_clr_end);
        end
        n_tests++;
        if (cap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_idle_line: got %b want 1", cap_idle);
        end
        u_if.tx_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_retrigger();
        logic [7:0] d1;
        int e1, c1, e2, c2, extra;
        d1 = 8'($urandom);
        u_if.tx_data  = d1;
        u_if.tx_start = 1'b1;
        capture_tx(1'b1);
        e1 = wave_err(d1);
        c1 = cap_clr;
        @(negedge clk);
        u_if.tx_data  = 8'h0A;
        u_if.tx_start = 1'b1;
        capture_tx(1'b0);
        e2 = wave_err(8'h0A);
        c2 = cap_clr;
        extra = 0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (u_if.tx_busy !== 1'b0) extra++;
        end
        u_if.tx_start = 1'b0;
        n_tests++;
        if (e1 !== 0 || c1 !== 1) begin
            n_fail++;
            $display("FAIL hold_frame1: got err=%0d clr=%0d want 0 1", e1, c1);
        end
        n_tests++;
        if (e2 !== 0 || c2 !== 1) begin
            n_fail++;
            $display("FAIL hold_frame2_0a: got err=%0d clr=%0d want 0 1", e2, c2);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL level_no_relaunch: got %0d busy cycles want 0", extra);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy_edge();
        logic [7:0] d;
        int e, extra;
        d = 8'($urandom);
        u_if.tx_data  = d;
        u_if.tx_start = 1'b1;
        fork
            capture_tx(1'b0);
            begin
                repeat (3 * CPB) @(negedge clk);
                u_if.tx_start = 1'b0;
                u_if.tx_data  = ~d;
                @(negedge clk);
                u_if.tx_start = 1'b1;
            end
        join
        e = wave_err(d);
        extra = 0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (u_if.tx_busy !== 1'b0) extra++;
        end
        u_if.tx_start = 1'b0;
        n_tests++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL busy_edge_latch: got %0d bad cycles want 0", e);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_edge_queued: got %0d busy cycles want 0", extra);
        end
        @(negedge clk);
    endtask

    task automatic test_tx_random();
        logic [7:0] d;
        int e;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            u_if.tx_data  = d;
            u_if.tx_start = 1'b1;
            capture_tx(1'b1);
            u_if.tx_start = 1'b0;
            e = wave_err(d);
            n_tests++;
            if (e !== 0 || cap_busy !== 10 * CPB || cap_clr !== 1) begin
                n_fail++;
                $display("FAIL tx_rand_%02h: got err=%0d busy=%0d clr=%0d want 0 %0d 1",
                         d, e, cap_busy, cap_clr, 10 * CPB);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rx_back_to_back();
        logic [7:0] g0, g1;
        rx_got.delete();
        rx_err_n = 0;
        @(negedge clk);
        send_rx(8'h41, 1'b1);
        send_rx(8'h0A, 1'b1);
        repeat (CPB) @(negedge clk);
        g0 = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
        g1 = (rx_got.size() > 1) ? rx_got[1] : 8'hxx;
        n_tests++;
        if (rx_got.size() !== 2) begin
            n_fail++;
            $display("FAIL rx_b2b_count: got %0d want 2", rx_got.size());
        end
        n_tests++;
        if ({g0, g1} !== 16'h410A) begin
            n_fail++;
            $display("FAIL rx_b2b_data: got %h want 410a", {g0, g1});
        end
        n_tests++;
        if (rx_err_n !== 0 || u_if.rx_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL rx_b2b_final: got err=%0d data=%h want 0 0a",
                     rx_err_n, u_if.rx_data);
        end
        last_good = 8'h0A;
    endtask

    task automatic test_rx_framing();
        rx_got.delete();
        rx_err_n = 0;
        send_rx(8'h55, 1'b0);
        repeat (CPB) @(negedge clk);
        n_tests++;
        if (rx_err_n !== 1 || rx_got.size() !== 0) begin
            n_fail++;
            $display("FAIL rx_framing: got err=%0d valid=%0d want 1 0",
                     rx_err_n, rx_got.size());
        end
        n_tests++;
        if (u_if.rx_data !== last_good) begin
            n_fail++;
            $display("FAIL rx_framing_data: got %h want %h", u_if.rx_data, last_good);
        end
    endtask

    task automatic test_rx_glitch();
        logic [7:0] d, g0;
        rx_got.delete();
        rx_err_n = 0;
        u_if.ser_rx = 1'b0;
        repeat (100) @(negedge clk);
        u_if.ser_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_tests++;
        if (rx_err_n !== 0 || rx_got.size() !== 0) begin
            n_fail++;
            $display("FAIL rx_glitch: got err=%0d valid=%0d want 0 0",
                     rx_err_n, rx_got.size());
        end
        d = 8'($urandom);
        send_rx(d, 1'b1);
        repeat (CPB) @(negedge clk);
        g0 = (rx_got.size() == 1) ? rx_got[0] : 8'hxx;
        n_tests++;
        if (g0 !== d || rx_err_n !== 0) begin
            n_fail++;
            $display("FAIL rx_after_glitch: got %h n=%0d want %h", g0, rx_got.size(), d);
        end
        last_good = d;
    endtask

    task automatic test_rx_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic       stopb;
        int         exp_err, bad;
        rx_got.delete();
        rx_err_n = 0;
        exp_err  = 0;
        for (int i = 0; i < 4; i++) begin
            d     = 8'($urandom);
            stopb = ($urandom_range(0, 3) != 0);
            send_rx(d, stopb);
            if (stopb) begin
                exp_q.push_back(d);
                last_good = d;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end else begin
                exp_err++;
                repeat (CPB) @(negedge clk);
            end
        end
        repeat (CPB) @(negedge clk);
        bad = 0;
        if (rx_got.size() != exp_q.size()) bad = 1;
        else foreach (exp_q[k]) if (rx_got[k] !== exp_q[k]) bad = 1;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rx_rand_bytes: got %0d bytes want %0d", rx_got.size(), exp_q.size());
        end
        n_tests++;
        if (rx_err_n !== exp_err || u_if.rx_data !== last_good) begin
            n_fail++;
            $display("FAIL rx_rand_state: got err=%0d data=%h want %0d %h",
                     rx_err_n, u_if.rx_data, exp_err, last_good);
        end
    endtask

    task automatic test_concurrent();
        logic [7:0] dt, dr, g0;
        int e;
        dt = 8'($urandom);
        dr = 8'($urandom);
        rx_got.delete();
        rx_err_n = 0;
        fork
            begin
                u_if.tx_data  = dt;
                u_if.tx_start = 1'b1;
                capture_tx(1'b1);
            end
            send_rx(dr, 1'b1);
        join
        u_if.tx_start = 1'b0;
        repeat (4) @(negedge clk);
        e  = wave_err(dt);
        g0 = (rx_got.size() == 1) ? rx_got[0] : 8'hxx;
        n_tests++;
        if (e !== 0 || g0 !== dr) begin
            n_fail++;
            $display("FAIL concurrent: got txerr=%0d rx=%h want 0 %h", e, g0, dr);
        end
        last_good = dr;
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d, d2;
        logic       pre_busy;
        int         pulses, e;
        d = 8'($urandom);
        u_if.tx_data  = d;
        u_if.tx_start = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        pre_busy = u_if.tx_busy;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({pre_busy, u_if.ser_tx, u_if.tx_busy, u_if.rx_data} !== {3'b110, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_abort: got busy_before=%b tx=%b busy=%b rxd=%h want 1 1 0 00",
                     pre_busy, u_if.ser_tx, u_if.tx_busy, u_if.rx_data);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (u_if.tx_clear_req !== 1'b0 || u_if.rx_valid !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d want 0", pulses);
        end
        d2 = 8'($urandom);
        u_if.tx_data = d2;
        rstn = 1'b1;
        capture_tx(1'b1);
        u_if.tx_start = 1'b0;
        e = wave_err(d2);
        n_tests++;
        if (cap_lat !== 1 || e !== 0) begin
            n_fail++;
            $display("FAIL start_held_over_reset: got lat=%0d err=%0d want 1 0", cap_lat, e);
        end
        last_good = 8'h00;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rx_err_n      = 0;
        last_good     = 8'h00;
        u_if.tx_start = 1'b0;
        u_if.tx_data  = 8'h00;
        u_if.ser_rx   = 1'b1;
        test_reset();
        test_tx_frame();
        test_hold_retrigger();
        test_ignore_busy_edge();
        test_tx_random();
        test_rx_back_to_back();
        test_rx_framing();
        test_rx_glitch();
        test_rx_random();
        test_concurrent();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
